// File: rtl/rs_encoder_stream.sv
// Streaming systematic Reed-Solomon encoder over GF(2^SYM_W): K message symbols in, N symbols out.
// Optional shortened-code support (per-codeword msgLen port) is enabled with `define RS_ENC_SHORTEN_EN.
module rs_encoder_stream #(
    parameter int SYM_W     = 4,
    parameter int N         = 15,
    parameter int K         = 9,
    parameter int PRIM_POLY = 'h13,
    parameter int FCR       = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inValid,
    output logic             inReady,
    input  logic [SYM_W-1:0] inData,
    output logic             outValid,
    input  logic             outReady,
    output logic [SYM_W-1:0] outData,
    output logic             outFirst,
    output logic             outLast,
    output logic             busy,
`ifdef RS_ENC_SHORTEN_EN
    input  logic [$clog2(K+1)-1:0] msgLen,
`endif
    output logic [1:0]       dbgState
);
    localparam int NPAR  = N - K;
    localparam int CNT_W = $clog2(((K > NPAR) ? K : NPAR) + 1);
    localparam logic [SYM_W-1:0] POLY_LO = SYM_W'(PRIM_POLY);

    // Handshake: a symbol moves in on inValid & inReady and out on outValid & outReady.
    // The output register may load whenever it is empty or being drained this cycle.

    function automatic logic [SYM_W-1:0] gfMul(input logic [SYM_W-1:0] a, input logic [SYM_W-1:0] b);
        logic [SYM_W-1:0] acc;
        logic [SYM_W-1:0] x;
        acc = '0;
        x   = a;
        for (int i = 0; i < SYM_W; i++) begin
            if (b[i]) acc = acc ^ x;
            x = x[SYM_W-1] ? ((x << 1) ^ POLY_LO) : (x << 1);
        end
        return acc;
    endfunction

    // Expands prod (x + alpha^i) for i = FCR..FCR+NPAR-1; the monic top term is dropped.
    function automatic logic [NPAR*SYM_W-1:0] genPoly();
        logic [(NPAR+1)*SYM_W-1:0] c;
        logic [SYM_W-1:0] root;
        logic [SYM_W-1:0] lo;
        c = '0;
        c[SYM_W-1:0] = SYM_W'(1);
        root = SYM_W'(1);
        for (int i = 0; i < FCR; i++) root = gfMul(root, SYM_W'(2));
        for (int k = 0; k < NPAR; k++) begin
            for (int j = k + 1; j >= 0; j--) begin
                lo = '0;
                if (j > 0) lo = c[(j-1)*SYM_W +: SYM_W];
                c[j*SYM_W +: SYM_W] = lo ^ gfMul(c[j*SYM_W +: SYM_W], root);
            end
            root = gfMul(root, SYM_W'(2));
        end
        return c[NPAR*SYM_W-1:0];
    endfunction

    localparam logic [NPAR-1:0][SYM_W-1:0] GEN = genPoly();

    typedef enum logic [1:0] {IDLE = 2'd0, MSG = 2'd1, PAR = 2'd2} state_t;

    state_t                       state, stateNext;
    logic [CNT_W-1:0]             cnt;
    logic [CNT_W-1:0]             lenReg;
    logic [CNT_W-1:0]             firstLen;
    logic [NPAR-1:0][SYM_W-1:0]   par;
    logic [NPAR-1:0][SYM_W-1:0]   parNext;
    logic [SYM_W-1:0]             fb;
    logic                         slotFree;
    logic                         accept;
    logic                         lastMsg;
    logic                         lastPar;

`ifdef RS_ENC_SHORTEN_EN
    assign firstLen = (msgLen == '0 || msgLen > ($clog2(K+1))'(K)) ? CNT_W'(K) : CNT_W'(msgLen);
`else
    assign firstLen = CNT_W'(K);
`endif

    assign slotFree = !outValid || outReady;
    assign accept   = inValid && inReady;
    assign lastMsg  = (state == IDLE) ? (firstLen == CNT_W'(1)) : ((cnt + CNT_W'(1)) == lenReg);
    assign lastPar  = (cnt == CNT_W'(NPAR - 1));

    always_comb begin
        fb = inData ^ par[NPAR-1];
        parNext[0] = gfMul(fb, GEN[0]);
        for (int i = 1; i < NPAR; i++) parNext[i] = par[i-1] ^ gfMul(fb, GEN[i]);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else        state <= stateNext;
    end

    always_comb begin
        stateNext = state;
        case (state)
            IDLE:    if (accept) stateNext = lastMsg ? PAR : MSG;
            MSG:     if (accept && lastMsg) stateNext = PAR;
            PAR:     if (slotFree && lastPar) stateNext = IDLE;
            default: stateNext = IDLE;
        endcase
    end

    always_comb begin
        inReady  = (state == IDLE || state == MSG) && slotFree;
        busy     = (state != IDLE) || outValid;
        dbgState = state;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            par      <= '0;
            cnt      <= '0;
            lenReg   <= '0;
            outValid <= 1'b0;
            outFirst <= 1'b0;
            outLast  <= 1'b0;
            outData  <= '0;
        end else if (accept) begin
            outData  <= inData;
            outValid <= 1'b1;
            outFirst <= (state == IDLE);
            outLast  <= 1'b0;
            par      <= parNext;
            if (lastMsg)            cnt <= '0;
            else if (state == IDLE) cnt <= CNT_W'(1);
            else                    cnt <= cnt + CNT_W'(1);
            if (state == IDLE) lenReg <= firstLen;
        end else if (state == PAR && slotFree) begin
            // Parity drains highest degree first; zeros shift in so p is clear for the next codeword.
            outData  <= par[NPAR-1];
            outValid <= 1'b1;
            outFirst <= 1'b0;
            outLast  <= lastPar;
            par      <= {par[NPAR-2:0], {SYM_W{1'b0}}};
            cnt      <= lastPar ? '0 : cnt + CNT_W'(1);
        end else if (outReady) begin
            outValid <= 1'b0;
            outFirst <= 1'b0;
            outLast  <= 1'b0;
        end
    end
endmodule
